// File: rtl/wb_dsp_pkg.sv
// Register map and bit positions shared by the Wishbone sample FIFO slave.
package wb_dsp_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_FLUSH = 1;
  localparam int unsigned STAT_EMPTY = 16;
  localparam int unsigned STAT_FULL  = 17;
  localparam int unsigned STAT_OVF   = 18;

  typedef enum logic [1:0] {
    RegCtrl   = REG_CTRL,
    RegStatus = REG_STATUS,
    RegData   = REG_DATA,
    RegRsvd   = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/wb_dsp_sync_fifo.sv
// Synchronous sample FIFO with occupancy counter; flush beats push and pop.
module wb_dsp_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [FIFO_AW:0]      level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [FIFO_AW:0] DEPTH_LVL = FIFO_DEPTH[FIFO_AW:0];

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == DEPTH_LVL);
  assign empty   = (level == '0);
  // A push into a full FIFO is only legal when a pop frees the slot this cycle.
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wb_sample_fifo_slave.sv
// Wishbone classic slave that buffers written samples and streams them out valid/ready.
module wb_sample_fifo_slave
  import wb_dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [3:0]            wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  irq_o
);

  logic                  ack;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  en;
  logic                  ovf;
  reg_sel_e              sel;
  logic                  req;
  logic                  wr;
  logic                  push_req;
  logic                  flush;
  logic                  ovf_clr;
  logic                  pop;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] rdata;
  logic [FIFO_AW:0]      level;
  logic                  full;
  logic                  empty;
  logic                  unused_bus;

  assign unused_bus = ^{wb_sel_i, wb_adr_i[1:0]};

  assign sel      = reg_sel_e'(wb_adr_i[3:2]);
  // Gating with ack makes a held strobe produce one access every other cycle.
  assign req      = wb_cyc_i & wb_stb_i & ~ack;
  assign wr       = req & wb_we_i;
  assign push_req = wr && (sel == RegData);
  assign flush    = wr && (sel == RegCtrl) && wb_dat_i[CTRL_FLUSH];
  assign ovf_clr  = wr && (sel == RegStatus) && wb_dat_i[STAT_OVF];

  assign sample_valid_o = en & ~empty;
  assign pop            = sample_valid_o & sample_ready_i;
  assign overflow       = push_req & full & ~pop;

  always_comb begin
    rdata = '0;
    case (sel)
      RegCtrl: begin
        rdata[CTRL_EN] = en;
      end
      RegStatus: begin
        rdata[FIFO_AW:0]  = level;
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_FULL]  = full;
        rdata[STAT_OVF]   = ovf;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack    <= 1'b0;
      rd_dat <= '0;
      en     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      ack    <= req;
      rd_dat <= (req && !wb_we_i) ? rdata : '0;
      if (wr && (sel == RegCtrl)) begin
        en <= wb_dat_i[CTRL_EN];
      end
      if (overflow) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign wb_ack_o = ack;
  assign wb_dat_o = rd_dat;
  assign irq_o    = ovf;

  wb_dsp_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .din   (wb_dat_i),
    .dout  (sample_o),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule
